// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
// game_round_ctrl : 1 Hz whack-a-mole round sequencer (ready/play/warn/over)
// Rev 1.0
// ============================================================================
module game_round_ctrl #(
  parameter int READY_SEC = 3,
  parameter int WARN_SEC  = 10,
  parameter int HOLD_SEC  = 5
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [5:0] time_left,
  input  logic [7:0] score,
  output logic       timer_enable,
  output logic       timer_rst_n,
  output logic [2:0] phase,
  output logic [1:0] ready_cnt,
  output logic [3:0] elapsed_tens,
  output logic [3:0] elapsed_ones,
  output logic       warn_blink,
  output logic       game_over,
  output logic [7:0] high_score
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_WARN  = 3'd3,
    S_OVER  = 3'd4
  } phase_t;

  localparam logic [1:0] READY_INIT = 2'(READY_SEC);
  localparam logic [3:0] HOLD_INIT  = 4'(HOLD_SEC);
  localparam logic [5:0] WARN_LEVEL = 6'(WARN_SEC);

  phase_t     phase_q;
  logic [1:0] ready_q;
  logic [3:0] tens_q, ones_q;
  logic [3:0] tens_d, ones_d;
  logic [3:0] hold_q;
  logic       blink_q;
  logic       en_q;
  logic       rstn_q;
  logic       over_q;
  logic [7:0] high_q;

  // Saturating BCD increment of the elapsed-seconds display
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (ones_q == 4'd9) begin
      if (tens_q != 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end
    end else begin
      ones_d = ones_q + 4'd1;
    end
  end

  always_ff @(posedge clk_1Hz or negedge reset) begin
    if (!reset) begin
      phase_q <= S_IDLE;
      ready_q <= 2'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      hold_q  <= 4'd0;
      blink_q <= 1'b0;
      en_q    <= 1'b0;
      rstn_q  <= 1'b0;
      over_q  <= 1'b0;
      high_q  <= 8'd0;
    end else begin
      case (phase_q)
        S_IDLE: begin
          en_q    <= 1'b0;
          rstn_q  <= 1'b0;
          ready_q <= 2'd0;
          tens_q  <= 4'd0;
          ones_q  <= 4'd0;
          blink_q <= 1'b0;
          over_q  <= 1'b0;
          if (start) begin
            phase_q <= S_READY;
            ready_q <= READY_INIT;
            rstn_q  <= 1'b1;
          end
        end

        S_READY: begin
          if (ready_q <= 2'd1) begin
            phase_q <= S_PLAY;
            ready_q <= 2'd0;
            en_q    <= 1'b1;
          end else begin
            ready_q <= ready_q - 2'd1;
          end
        end

        S_PLAY, S_WARN: begin
          // Expiry outranks pause so a paused final second still ends the round
          if (time_left == 6'd0) begin
            phase_q <= S_OVER;
            en_q    <= 1'b0;
            over_q  <= 1'b1;
            blink_q <= 1'b0;
            hold_q  <= HOLD_INIT;
            if (score > high_q) begin
              high_q <= score;
            end
          end else if (pause) begin
            en_q <= 1'b0;
          end else begin
            en_q   <= 1'b1;
            tens_q <= tens_d;
            ones_q <= ones_d;
            if (phase_q == S_WARN) begin
              blink_q <= ~blink_q;
            end else if (time_left <= WARN_LEVEL) begin
              phase_q <= S_WARN;
              blink_q <= 1'b1;
            end
          end
        end

        S_OVER: begin
          en_q    <= 1'b0;
          blink_q <= 1'b0;
          if (hold_q <= 4'd1) begin
            phase_q <= S_IDLE;
            over_q  <= 1'b0;
            rstn_q  <= 1'b0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end

        default: begin
          phase_q <= S_IDLE;
          ready_q <= 2'd0;
          tens_q  <= 4'd0;
          ones_q  <= 4'd0;
          hold_q  <= 4'd0;
          blink_q <= 1'b0;
          en_q    <= 1'b0;
          rstn_q  <= 1'b0;
          over_q  <= 1'b0;
        end
      endcase
    end
  end

  assign phase        = phase_q;
  assign ready_cnt    = ready_q;
  assign elapsed_tens = tens_q;
  assign elapsed_ones = ones_q;
  assign warn_blink   = blink_q;
  assign timer_enable = en_q;
  assign timer_rst_n  = rstn_q;
  assign game_over    = over_q;
  assign high_score   = high_q;

endmodule
`default_nettype wire
